// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the fetch-PC sequencer state.
package y86_pkg;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RET_WAIT = 2'd1,
      HALTED   = 2'd2
   } pcs_state_t;

endpackage

// File: rtl/pcs_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module pcs_ras #(
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  top_idx;
   logic [CNT_W-1:0]  cnt;

   // ptr names the next free slot; it wraps naturally since RAS_DEPTH is a power of 2
   assign top_idx = ptr - PTR_ONE;
   assign top     = mem[top_idx];
   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_ONE;
         if (!full) cnt <= cnt + CNT_ONE;
      end else if (pop && !empty) begin
         ptr <= top_idx;
         cnt <= cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= din;
   end

endmodule

// File: rtl/pc_predict_select.sv
// Fetch-PC selection and ret/halt sequencing for the Y86-64 pipeline.
// Optional return-address stack enabled by defining PCS_RAS_EN.
module pc_predict_select
   import y86_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 64,
   parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
   parameter int unsigned          RAS_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_stall,
   input  logic [3:0]        f_icode,
   input  logic [ADDR_W-1:0] f_valC,
   input  logic [ADDR_W-1:0] f_valP,
   input  logic [3:0]        m_icode,
   input  logic              m_cnd,
   input  logic [ADDR_W-1:0] m_valA,
   input  logic [3:0]        w_icode,
   input  logic [ADDR_W-1:0] w_valM,
   input  logic [ADDR_W-1:0] w_pred_ret,
   output logic [ADDR_W-1:0] f_pc,
   output logic [ADDR_W-1:0] pred_pc,
   output logic              redirect,
   output logic              ret_pending,
   output logic              halted
);

   pcs_state_t        state;
   logic              w_redir;
   logic              m_redir;
   logic              active;
   logic              ras_hit;
   logic [ADDR_W-1:0] ras_top;

`ifdef PCS_RAS_EN
   logic ras_push;
   logic ras_pop;
   logic ras_empty;
   logic unused_ras_full;

   // A correctly predicted return needs no redirect
   assign w_redir  = (w_icode == RET) && (w_valM != w_pred_ret);
   assign ras_hit  = !ras_empty;
   assign ras_push = active && (f_icode == CALL);
   assign ras_pop  = active && (f_icode == RET) && ras_hit;

   pcs_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (f_valP),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (unused_ras_full)
   );
`else
   localparam int unsigned unused_ras_depth = RAS_DEPTH;
   logic unused_pred_ret;

   assign w_redir         = (w_icode == RET);
   assign ras_hit         = 1'b0;
   assign ras_top         = '0;
   assign unused_pred_ret = ^w_pred_ret;
`endif

   assign m_redir  = (m_icode == JXX) && !m_cnd;
   assign redirect = w_redir || m_redir;

   always_comb begin
      f_pc = pred_pc;
      if (w_redir)      f_pc = w_valM;
      else if (m_redir) f_pc = m_valA;
   end

   // A redirect overrides both the stall and any wait state
   assign active = redirect || (!f_stall && (state == IDLE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         pred_pc <= RESET_PC;
      end else if (active) begin
         case (f_icode)
            RET: begin
               if (ras_hit) begin
                  pred_pc <= ras_top;
                  state   <= IDLE;
               end else begin
                  state   <= RET_WAIT;
               end
            end
            HALT: state <= HALTED;
            JXX, CALL: begin
               pred_pc <= f_valC;
               state   <= IDLE;
            end
            default: begin
               pred_pc <= f_valP;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign ret_pending = (state == RET_WAIT);
   assign halted      = (state == HALTED);

endmodule

// File: tb/tb_pc_predict_select.sv
// Self-checking bench for pc_predict_select: spec-level model plus directed literal checks.
module tb_pc_predict_select;

   localparam int unsigned AW   = 64;
   localparam logic [63:0] RPC  = 64'h100;
   localparam int unsigned DEPTH = 2;
`ifdef PCS_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_stall;
   logic [3:0]    f_icode, m_icode, w_icode;
   logic [63:0]   f_valC, f_valP, m_valA, w_valM, w_pred_ret;
   logic          m_cnd;
   logic [63:0]   f_pc, pred_pc;
   logic          redirect, ret_pending, halted;

   int checks = 0;
   int errors = 0;

   // Model: predicted PC, mode (0 idle, 1 waiting for ret, 2 halted), return stack
   logic [63:0] m_pred;
   int          m_mode;
   logic [63:0] m_ras [$];

   pc_predict_select #(
      .ADDR_W    (AW),
      .RESET_PC  (RPC),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .f_stall     (f_stall),
      .f_icode     (f_icode),
      .f_valC      (f_valC),
      .f_valP      (f_valP),
      .m_icode     (m_icode),
      .m_cnd       (m_cnd),
      .m_valA      (m_valA),
      .w_icode     (w_icode),
      .w_valM      (w_valM),
      .w_pred_ret  (w_pred_ret),
      .f_pc        (f_pc),
      .pred_pc     (pred_pc),
      .redirect    (redirect),
      .ret_pending (ret_pending),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit exp_wret();
      return (w_icode == 4'h9) && (!RAS_EN || (w_valM != w_pred_ret));
   endfunction

   function automatic bit exp_redirect();
      return exp_wret() || ((m_icode == 4'h7) && !m_cnd);
   endfunction

   function automatic logic [63:0] exp_fpc();
      if (exp_wret()) return w_valM;
      if ((m_icode == 4'h7) && !m_cnd) return m_valA;
      return m_pred;
   endfunction

   task automatic model_reset();
      m_pred = RPC;
      m_mode = 0;
      m_ras.delete();
   endtask

   task automatic model_step();
      if (exp_redirect() || (!f_stall && m_mode == 0)) begin
         m_mode = 0;
         if (f_icode == 4'h9) begin
            if (RAS_EN && m_ras.size() > 0) m_pred = m_ras.pop_back();
            else m_mode = 1;
         end else if (f_icode == 4'h0) begin
            m_mode = 2;
         end else if (f_icode == 4'h7 || f_icode == 4'h8) begin
            m_pred = f_valC;
            if (RAS_EN && f_icode == 4'h8) begin
               if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
               m_ras.push_back(f_valP);
            end
         end else begin
            m_pred = f_valP;
         end
      end
   endtask

   // Compare all outputs against the model mid-cycle, then advance both on the edge
   task automatic cycle();
      @(negedge clk);
      chk("f_pc", f_pc, exp_fpc());
      chk("pred_pc", pred_pc, m_pred);
      chk("redirect", {63'b0, redirect}, {63'b0, exp_redirect()});
      chk("ret_pending", {63'b0, ret_pending}, {63'b0, m_mode == 1});
      chk("halted", {63'b0, halted}, {63'b0, m_mode == 2});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet();
      f_stall = 1'b0; f_icode = 4'h1; f_valC = '0; f_valP = '0;
      m_icode = 4'h1; m_cnd = 1'b0; m_valA = '0;
      w_icode = 4'h1; w_valM = '0; w_pred_ret = '0;
   endtask

   task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
      quiet();
      f_icode = ic; f_valC = vc; f_valP = vp;
   endtask

   initial begin
      rst_n = 1'b0;
      quiet();
      model_reset();
      @(negedge clk);
      chk("rst_f_pc", f_pc, 64'h100);
      chk("rst_pred_pc", pred_pc, 64'h100);
      chk("rst_flags", {61'b0, redirect, ret_pending, halted}, 64'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Sequential fetch and predict-taken jump, then mispredict from M
      fetch(4'h1, 64'h0, 64'h101); cycle();
      chk("t1_pred", pred_pc, 64'h101);
      fetch(4'h7, 64'h200, 64'h109); cycle();
      chk("t2_pred", pred_pc, 64'h200);
      fetch(4'h1, 64'h0, 64'h201); cycle();
      fetch(4'h1, 64'h0, 64'h10a);
      m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h109;
      #1;
      chk("t2_mis_fpc", f_pc, 64'h109);
      chk("t2_mis_redir", {63'b0, redirect}, 64'h1);
      cycle();
      chk("t2_after_pred", pred_pc, 64'h10a);
      // Taken branch resolved in M: no redirect
      fetch(4'h1, 64'h0, 64'h10b); m_icode = 4'h7; m_cnd = 1'b1; m_valA = 64'h999; cycle();

      // Return with no prediction: bubbles until W supplies the address
      fetch(4'h9, 64'h0, 64'h10c); cycle();
      chk("t3_pending", {63'b0, ret_pending}, 64'h1);
      fetch(4'h8, 64'h777, 64'h778); cycle();
      fetch(4'h7, 64'h555, 64'h556); cycle();
      chk("t3_frozen", pred_pc, 64'h10b);
      fetch(4'h1, 64'h0, 64'h341); w_icode = 4'h9; w_valM = 64'h340; w_pred_ret = 64'h0;
      #1;
      chk("t3_w_fpc", f_pc, 64'h340);
      chk("t3_w_redir", {63'b0, redirect}, 64'h1);
      cycle();
      chk("t3_exit", {63'b0, ret_pending}, 64'h0);
      chk("t3_pred", pred_pc, 64'h341);

      // Wrong-path halt recovered by M mispredict
      fetch(4'h0, 64'h0, 64'h342); cycle();
      chk("t4_halted", {63'b0, halted}, 64'h1);
      fetch(4'h6, 64'h0, 64'h999); cycle();
      fetch(4'h1, 64'h0, 64'h51); m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h50;
      #1;
      chk("t4_fpc", f_pc, 64'h50);
      cycle();
      chk("t4_unhalt", {63'b0, halted}, 64'h0);
      chk("t4_pred", pred_pc, 64'h51);

      // Stall holds everything; W beats M when both redirect
      fetch(4'h9, 64'h0, 64'h52); f_stall = 1'b1; cycle();
      chk("stall_ret", {63'b0, ret_pending}, 64'h0);
      chk("stall_pred", pred_pc, 64'h51);
      fetch(4'h7, 64'h600, 64'h52); f_stall = 1'b1; cycle();
      fetch(4'h1, 64'h0, 64'h61); f_stall = 1'b1;
      m_icode = 4'h7; m_valA = 64'h70; w_icode = 4'h9; w_valM = 64'h60; w_pred_ret = 64'h1;
      #1;
      chk("prio_fpc", f_pc, 64'h60);
      cycle();
      chk("redir_stall_pred", pred_pc, 64'h61);

`ifdef PCS_RAS_EN
      // Predicted return, then W confirms or corrects
      fetch(4'h8, 64'h300, 64'h40); cycle();
      fetch(4'h9, 64'h0, 64'h301); cycle();
      chk("t5_pred", pred_pc, 64'h40);
      chk("t5_nowait", {63'b0, ret_pending}, 64'h0);
      fetch(4'h1, 64'h0, 64'h41); w_icode = 4'h9; w_valM = 64'h40; w_pred_ret = 64'h40;
      #1;
      chk("t5_match", {63'b0, redirect}, 64'h0);
      cycle();
      fetch(4'h1, 64'h0, 64'h49); w_icode = 4'h9; w_valM = 64'h48; w_pred_ret = 64'h40;
      #1;
      chk("t5_fix_fpc", f_pc, 64'h48);
      cycle();
      // Overflowing a 2-entry stack loses the oldest return
      fetch(4'h8, 64'h400, 64'h10); cycle();
      fetch(4'h8, 64'h500, 64'h20); cycle();
      fetch(4'h8, 64'h600, 64'h30); cycle();
      fetch(4'h9, 64'h0, 64'h0); cycle();
      chk("t6_r1", pred_pc, 64'h30);
      cycle();
      chk("t6_r2", pred_pc, 64'h20);
      cycle();
      chk("t6_r3_wait", {63'b0, ret_pending}, 64'h1);
`else
      fetch(4'h9, 64'h0, 64'h62); cycle();
      chk("ret_wait_again", {63'b0, ret_pending}, 64'h1);
`endif

      // Asynchronous reset while waiting on a return
      fetch(4'h9, 64'h0, 64'h0); cycle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pred", pred_pc, 64'h100);
      chk("mid_rst_pending", {63'b0, ret_pending}, 64'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Mixed traffic against the model
      for (int i = 0; i < 80; i++) begin
         quiet();
         case ($urandom_range(0, 7))
            0: f_icode = 4'h9;
            1: f_icode = 4'h0;
            2: f_icode = 4'h7;
            3: f_icode = 4'h8;
            default: f_icode = 4'($urandom_range(1, 11));
         endcase
         f_valC = {32'h0, $urandom()};
         f_valP = {32'h0, $urandom()};
         f_stall = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 4) == 0) begin
            m_icode = 4'h7; m_cnd = $urandom_range(0, 1) == 1; m_valA = {32'h0, $urandom()};
         end
         if ($urandom_range(0, 5) == 0) begin
            w_icode = 4'h9; w_valM = {32'h0, $urandom()};
            w_pred_ret = ($urandom_range(0, 1) == 1) ? w_valM : 64'h0;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
